// File: rtl/noc_flit_vc_injector.sv
// noc_flit_vc_injector: transmit end of a NoC flit link.
// A single-lane local flit stream (tagged with a VC id) fills one staging slot
// per VC. A round-robin arbiter picks among VCs whose slot is full and whose
// downstream vc_ready is high, loading a single registered output stage that
// drives the link with a one-hot per-VC valid. Each VC tracks packet framing.
// Optional feature macro: NOC_TX_FLIT_COUNT_EN (saturating link flit counter).
module noc_flit_vc_injector #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 32,
    parameter int HEAD_BIT   = FLIT_WIDTH - 1,
    parameter int TAIL_BIT   = FLIT_WIDTH - 2,
    parameter int VCW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    input  logic                  i_clear,
    input  logic                  i_src_valid,
    output logic                  o_src_ready,
    input  logic [VCW-1:0]        i_src_vc,
    input  logic [FLIT_WIDTH-1:0] i_src_flit,
    output logic [CHANNELS-1:0]   o_link_valid,
    output logic [FLIT_WIDTH-1:0] o_link_flit,
    input  logic [CHANNELS-1:0]   i_link_ready,
    input  logic [CHANNELS-1:0]   i_link_vc_ready,
    output logic [CHANNELS-1:0]   o_busy,
    output logic                  o_proto_err,
    output logic [31:0]           o_flit_count
);

    typedef enum logic {ST_IDLE, ST_PKT} pkt_state_t;

    // Reset and clear share one flush path.
    logic flush;
    assign flush = noc_rst | i_clear;

    // Staging slots, one per VC.
    logic [CHANNELS-1:0]   slot_full_reg;
    logic [FLIT_WIDTH-1:0] slot_flit_reg [CHANNELS];

    // Single-entry output stage.
    logic                  out_valid_reg;
    logic [VCW-1:0]        out_vc_reg;
    logic [FLIT_WIDTH-1:0] out_flit_reg;

    logic [VCW-1:0]        ptr_reg;
    logic                  proto_err_reg;

    logic                  transfer;
    logic                  out_free;
    logic [CHANNELS-1:0]   eligible;
    logic                  grant_valid;
    logic [VCW-1:0]        grant_vc;
    logic [VCW:0]          cand;

    logic [VCW-1:0]        src_vc;
    logic                  src_vc_ok;
    logic                  src_ready;
    logic                  accept;

    logic [CHANNELS-1:0]   vc_busy;
    logic [CHANNELS-1:0]   vc_err;

    // With one VC the id input carries no information.
    assign src_vc    = (CHANNELS == 1) ? '0 : i_src_vc;
    assign src_vc_ok = (CHANNELS == 1) || ({1'b0, i_src_vc} < (VCW+1)'(CHANNELS));

    assign transfer = out_valid_reg & i_link_ready[out_vc_reg];
    assign out_free = ~out_valid_reg | transfer;
    assign eligible = slot_full_reg & i_link_vc_ready;

    // Round-robin search from ptr upward with wrap; first eligible VC wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_vc    = '0;
        cand        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = (VCW+1)'(ptr_reg) + (VCW+1)'(i);
            if (cand >= (VCW+1)'(CHANNELS))
                cand = cand - (VCW+1)'(CHANNELS);
            if (!grant_valid && out_free && eligible[cand[VCW-1:0]]) begin
                grant_valid = 1'b1;
                grant_vc    = cand[VCW-1:0];
            end
        end
    end

    // Source may write a slot that is empty or being drained this cycle.
    always_comb begin
        src_ready = 1'b0;
        if (!flush && src_vc_ok)
            src_ready = !slot_full_reg[src_vc] || (grant_valid && (grant_vc == src_vc));
    end

    assign o_src_ready = src_ready;
    assign accept      = i_src_valid & src_ready;

    // Slot fill/drain; a same-cycle drain and refill leaves the slot full.
    always_ff @(posedge noc_clk) begin
        if (flush) begin
            slot_full_reg <= '0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                if (grant_valid && (grant_vc == VCW'(v)))
                    slot_full_reg[v] <= 1'b0;
                if (accept && (src_vc == VCW'(v))) begin
                    slot_full_reg[v] <= 1'b1;
                    slot_flit_reg[v] <= i_src_flit;
                end
            end
        end
    end

    // Output stage load and round-robin pointer advance.
    always_ff @(posedge noc_clk) begin
        if (flush) begin
            out_valid_reg <= 1'b0;
            out_vc_reg    <= '0;
            out_flit_reg  <= '0;
            ptr_reg       <= '0;
        end else if (out_free) begin
            out_valid_reg <= grant_valid;
            if (grant_valid) begin
                out_vc_reg   <= grant_vc;
                out_flit_reg <= slot_flit_reg[grant_vc];
                ptr_reg      <= (grant_vc == VCW'(CHANNELS - 1)) ? '0 : grant_vc + VCW'(1);
            end
        end
    end

    // Decode the held VC into the one-hot link valid.
    always_comb begin
        o_link_valid = '0;
        if (out_valid_reg)
            o_link_valid[out_vc_reg] = 1'b1;
    end

    assign o_link_flit = out_flit_reg;

    // Per-VC packet framing FSMs, advanced by link transfers on that VC.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_vc
            pkt_state_t state_reg;
            pkt_state_t state_next;
            logic       hit;
            logic       err_hit;

            assign hit = transfer && (out_vc_reg == VCW'(gi));

            // State register.
            always_ff @(posedge noc_clk) begin
                if (flush)
                    state_reg <= ST_IDLE;
                else
                    state_reg <= state_next;
            end

            // Next state and framing-error strobe.
            always_comb begin
                state_next = state_reg;
                err_hit    = 1'b0;
                if (hit) begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (out_flit_reg[HEAD_BIT])
                                state_next = out_flit_reg[TAIL_BIT] ? ST_IDLE : ST_PKT;
                            else
                                err_hit = 1'b1;
                        end
                        ST_PKT: begin
                            if (out_flit_reg[HEAD_BIT]) begin
                                err_hit    = 1'b1;
                                state_next = out_flit_reg[TAIL_BIT] ? ST_IDLE : ST_PKT;
                            end else if (out_flit_reg[TAIL_BIT]) begin
                                state_next = ST_IDLE;
                            end
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end

            assign vc_busy[gi] = (state_reg == ST_PKT);
            assign vc_err[gi]  = err_hit;
        end
    endgenerate

    assign o_busy = vc_busy;

    // Sticky error: framing violation or out-of-range source VC.
    always_ff @(posedge noc_clk) begin
        if (flush)
            proto_err_reg <= 1'b0;
        else if ((i_src_valid && !src_vc_ok) || (|vc_err))
            proto_err_reg <= 1'b1;
    end

    assign o_proto_err = proto_err_reg;

`ifdef NOC_TX_FLIT_COUNT_EN
    logic [31:0] flit_count_reg;

    // Saturating count of link transfers.
    always_ff @(posedge noc_clk) begin
        if (flush)
            flit_count_reg <= '0;
        else if (transfer && (flit_count_reg != 32'hFFFF_FFFF))
            flit_count_reg <= flit_count_reg + 32'd1;
    end

    assign o_flit_count = flit_count_reg;
`else
    assign o_flit_count = '0;
`endif

endmodule
